// File: rtl/ula_arbiter.sv
// rtl/ula_arbiter.sv - round-robin sequencer sharing one combinational ULA between two requesters
// One operation in flight: accept in IDLE, evaluate ULA in EXEC, hold response in RESP.
module ula_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    input  logic [OP_WIDTH-1:0]   req1_op,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_s,
    output logic                  rsp0_z,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_s,
    output logic                  rsp1_z,
    output logic [DATA_WIDTH-1:0] ula_a,
    output logic [DATA_WIDTH-1:0] ula_b,
    output logic [OP_WIDTH-1:0]   ula_op,
    input  logic [DATA_WIDTH-1:0] ula_s,
    input  logic                  ula_z
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant1;

    // On a tie the requester not served last wins; otherwise whoever is valid.
    always_comb begin
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant1 = ~last_grant;
        end else begin
            grant1 = req1_valid;
        end
        req0_ready = !reset && (state == IDLE) && req0_valid && !grant1;
        req1_ready = !reset && (state == IDLE) && req1_valid && grant1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            ula_a      <= '0;
            ula_b      <= '0;
            ula_op     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_s     <= '0;
            rsp0_z     <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_s     <= '0;
            rsp1_z     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        owner      <= grant1;
                        last_grant <= grant1;
                        ula_a      <= grant1 ? req1_a  : req0_a;
                        ula_b      <= grant1 ? req1_b  : req0_b;
                        ula_op     <= grant1 ? req1_op : req0_op;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // Only the owner's response registers are touched.
                    if (owner) begin
                        rsp1_s     <= ula_s;
                        rsp1_z     <= ula_z;
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_s     <= ula_s;
                        rsp0_z     <= ula_z;
                        rsp0_valid <= 1'b1;
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (owner && rsp1_ready) begin
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (!owner && rsp0_ready) begin
                        rsp0_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_arbiter.sv
// tb/tb_ula_arbiter.sv - self-checking bench for ula_arbiter with a transaction-level model
module tb_ula_arbiter;
    localparam int DW = 32;
    localparam int OW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [OW-1:0] req0_op = '0, req1_op = '0;
    logic          rsp0_valid, rsp1_valid;
    logic          rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [DW-1:0] rsp0_s, rsp1_s;
    logic          rsp0_z, rsp1_z;
    logic [DW-1:0] ula_a, ula_b, ula_s;
    logic [OW-1:0] ula_op;
    logic          ula_z;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [OW-1:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign ula_s = alu(ula_a, ula_b, ula_op);
    assign ula_z = (ula_s == '0);

    ula_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_s(rsp0_s), .rsp0_z(rsp0_z),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_s(rsp1_s), .rsp1_z(rsp1_z),
        .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op), .ula_s(ula_s), .ula_z(ula_z)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: an accepted op occupies the unit, its result appears one edge later
    // and is retired on the first edge where the owner's rsp_ready is high.
    bit            m_busy = 1'b0;
    int            m_age  = 0;
    bit            m_owner = 1'b0;
    bit            m_last  = 1'b1;
    logic [DW-1:0] m_s [2] = '{default: '0};
    bit            m_z [2] = '{default: 1'b0};
    bit            m_rv[2] = '{default: 1'b0};
    logic [DW-1:0] m_ua = '0, m_ub = '0;
    logic [OW-1:0] m_uop = '0;

    function automatic bit exp_ready(input bit n);
        if (reset || m_busy) return 1'b0;
        if (n) return req1_valid && (!req0_valid || !m_last);
        return req0_valid && (!req1_valid || m_last);
    endfunction

    always @(posedge clock) begin
        bit g0, g1;
        g0 = exp_ready(1'b0);
        g1 = exp_ready(1'b1);
        if (reset) begin
            m_busy = 1'b0; m_last = 1'b1;
            m_ua = '0; m_ub = '0; m_uop = '0;
            for (int i = 0; i < 2; i++) begin m_s[i] = '0; m_z[i] = 1'b0; m_rv[i] = 1'b0; end
        end else if (!m_busy) begin
            if (g0 || g1) begin
                m_owner = g1; m_last = g1;
                m_ua  = g1 ? req1_a  : req0_a;
                m_ub  = g1 ? req1_b  : req0_b;
                m_uop = g1 ? req1_op : req0_op;
                m_busy = 1'b1; m_age = 0;
            end
        end else if (m_age == 0) begin
            m_s[m_owner]  = alu(m_ua, m_ub, m_uop);
            m_z[m_owner]  = (m_s[m_owner] == '0);
            m_rv[m_owner] = 1'b1;
            m_age = 1;
        end else if (m_owner ? rsp1_ready : rsp0_ready) begin
            m_rv[m_owner] = 1'b0;
            m_busy = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("req0_ready", req0_ready, exp_ready(1'b0));
            chk("req1_ready", req1_ready, exp_ready(1'b1));
            chk("rsp0_valid", rsp0_valid, m_rv[0]);
            chk("rsp1_valid", rsp1_valid, m_rv[1]);
            chk("rsp0_s", rsp0_s, m_s[0]);
            chk("rsp1_s", rsp1_s, m_s[1]);
            chk("rsp0_z", rsp0_z, m_z[0]);
            chk("rsp1_z", rsp1_z, m_z[1]);
            chk("ula_a", ula_a, m_ua);
            chk("ula_b", ula_b, m_ub);
            chk("ula_op", ula_op, m_uop);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ready(input bit n);
        int k = 0;
        #1;
        while (!(n ? req1_ready : req0_ready) && k < 20) begin
            tick();
            k++;
        end
        chk(n ? "wait_req1_ready" : "wait_req0_ready", n ? req1_ready : req0_ready, 1);
    endtask

    task automatic do_op(input bit n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OW-1:0] op, input logic [DW-1:0] es, input logic ez);
        if (n) begin
            rsp1_ready = 1'b1; req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
        end else begin
            rsp0_ready = 1'b1; req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
        end
        wait_ready(n);
        tick();
        if (n) req1_valid = 1'b0; else req0_valid = 1'b0;
        tick();
        chk("op_rsp_valid", n ? rsp1_valid : rsp0_valid, 1);
        chk("op_rsp_s", n ? rsp1_s : rsp0_s, es);
        chk("op_rsp_z", n ? rsp1_z : rsp0_z, ez);
        chk("op_other_valid", n ? rsp0_valid : rsp1_valid, 0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        chk_en = 1'b1;
        chk("reset_req0_ready", req0_ready, 0);
        chk("reset_rsp0_valid", rsp0_valid, 0);
        chk("reset_ula_a", ula_a, 0);
        tick();
        reset = 1'b0;

        // Single ADD, then SUB to zero and SLT with a negative operand
        do_op(1'b0, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0);
        do_op(1'b1, 32'd3, 32'd3, 4'b0110, 32'd0, 1'b1);
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0);

        // Simultaneous requests after a fresh reset
        apply_reset();
        req0_a = 32'hF0F0_F0F0; req0_b = 32'hFF00_FF00; req0_op = 4'b0000;
        req1_a = 32'h1; req1_b = 32'h2; req1_op = 4'b0001;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("tie_req0_ready", req0_ready, 1);
        chk("tie_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        tick();
        chk("tie_rsp0_s", rsp0_s, 32'hF000_F000);
        chk("tie_req1_blocked", req1_ready, 0);
        tick();
        chk("tie_req1_ready_t3", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("tie_rsp1_s", rsp1_s, 32'd3);
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("next_tie_req0", req0_ready, 1);
        // Both held valid: grants must alternate
        repeat (15) tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (4) tick();

        // Backpressure on rsp0 while req1 waits
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        req0_a = 32'd1; req0_b = 32'd1; req0_op = 4'b0010; req0_valid = 1'b1;
        wait_ready(1'b0);
        tick();
        req0_valid = 1'b0;
        req1_a = 32'd10; req1_b = 32'd3; req1_op = 4'b0110; req1_valid = 1'b1;
        tick();
        repeat (4) begin
            chk("bp_rsp0_valid", rsp0_valid, 1);
            chk("bp_rsp0_s", rsp0_s, 32'd2);
            chk("bp_rsp0_z", rsp0_z, 0);
            chk("bp_req1_ready", req1_ready, 0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        chk("bp_req1_still_low", req1_ready, 0);
        tick();
        chk("bp_rsp0_cleared", rsp0_valid, 0);
        chk("bp_req1_ready", req1_ready, 1);
        tick();
        req1_valid = 1'b0;
        tick();
        chk("bp_rsp1_s", rsp1_s, 32'd7);
        tick();

        // Reset while in EXEC
        req0_a = 32'd9; req0_b = 32'd9; req0_op = 4'b0010; req0_valid = 1'b1;
        wait_ready(1'b0);
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp0_s", rsp0_s, 0);
        chk("rst_ula_a", ula_a, 0);
        reset = 1'b0;
        tick();
        chk("rst_no_rsp", rsp0_valid, 0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("rst_tie_req0", req0_ready, 1);
        chk("rst_tie_req1", req1_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();

        // Unsupported opcode
        do_op(1'b0, 32'd123, 32'd456, 4'b1111, 32'd0, 1'b1);

        // req1 withdrawn while busy must not move the pointer
        req0_a = 32'd4; req0_b = 32'd4; req0_op = 4'b0010; req0_valid = 1'b1;
        wait_ready(1'b0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b1;
        #1;
        chk("wd_req1_busy", req1_ready, 0);
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("wd_tie_req1", req1_ready, 1);
        chk("wd_tie_req0", req0_ready, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Sequencer and round-robin arbiter that shares the single 32-bit ULA between two requesters (e.g. main datapath and a branch/address unit). Each requester presents operands and an opcode with a valid/ready handshake. The block registers the accepted operation, drives the combinational ULA for one cycle, latches S and Z, and returns them on a per-requester response handshake.

## Interface
- `DATA_WIDTH`, 32, operand/result width (matches ULA)
- `OP_WIDTH`, 4, opcode width (matches ULA OP)
- `clock`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  requester N has an operation pending
- `req0_ready` / `req1_ready`  out  1  requester N's operation is accepted this cycle
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_WIDTH  operands A, B (signed)
- `req0_op` / `req1_op`  in  OP_WIDTH  ULA opcode, passed through unmodified
- `rsp0_valid` / `rsp1_valid`  out  1  result for requester N available
- `rsp0_ready` / `rsp1_ready`  in  1  requester N consumes its result
- `rsp0_s` / `rsp1_s`  out  DATA_WIDTH  latched ULA result
- `rsp0_z` / `rsp1_z`  out  1  latched ULA zero flag
- `ula_a`, `ula_b`  out  DATA_WIDTH  registered operands to ULA
- `ula_op`  out  OP_WIDTH  registered opcode to ULA
- `ula_s`  in  DATA_WIDTH  ULA result (combinational from ula_a/ula_b/ula_op)
- `ula_z`  in  1  ULA zero flag

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester with valid high.
  - If both are valid, grant goes to the requester not granted last (`last_grant` pointer).
  - `reqN_ready` = (state==IDLE) && grant==N; it is combinational from valid and pointer.
  - On handshake: capture a/b/op into `ula_a`/`ula_b`/`ula_op`, record owner = N, set `last_grant` = N, go to EXEC.
  - With no valid request, stay in IDLE; operand registers hold.
- EXEC (1 cycle): capture `ula_s`/`ula_z` into `rspN_s`/`rspN_z` of the owner, set `rspN_valid`, go to RESP.
- RESP: hold `rspN_valid`/`rspN_s`/`rspN_z` stable until `rspN_ready`=1. On that edge, clear `rspN_valid` and go to IDLE.
- Both `reqN_ready` signals are low in EXEC and RESP. There is one operation in flight at most.
- The non-owner's `rsp_s`/`rsp_z` keep their previous values. Its `rsp_valid` stays 0.
- Opcodes are not decoded. Unsupported opcodes yield whatever the ULA returns (S=0, Z=1).
- Operands are sampled only at accept. Later changes on `reqN_*` are ignored.
- A request withdrawn before being accepted is legal and leaves no side effect. The pointer updates only on an actual grant.
- Reset values:
  - state=IDLE.
  - `last_grant`=1, so req0 wins the first tie.
  - `ula_a`=`ula_b`=0, `ula_op`=0.
  - `rsp0_valid`=`rsp1_valid`=0, `rsp0_s`=`rsp1_s`=0, `rsp0_z`=`rsp1_z`=0.
  - `req0_ready`=`req1_ready`=0 during the reset cycle.
- Reset mid-operation (EXEC or RESP): the operation is dropped with no response, and all registers return to reset values next edge.

## Timing
- Accept at edge T (`reqN_valid` && `reqN_ready` sampled high).
  - `ula_*` are valid after T.
  - `rspN_valid`=1 after edge T+1.
  - Earliest consume at edge T+2, then IDLE after T+2.
  - Next accept is possible at edge T+3.
- Minimum occupancy is 3 cycles per operation. Throughput is ≤ 1 op / 3 cycles.
- `rspN_ready` already high when `rspN_valid` rises: completes at the first RESP edge, with no extra wait.
- Backpressure: every cycle `rspN_ready`=0 in RESP adds one cycle. The other requester stalls (ready=0).
- The ULA path is a single cycle from the `ula_*` registers to the `rsp` registers. No combinational path from `ula_s` to any output.
- Fairness: with both requesters continuously valid and responses consumed immediately, grants alternate 0,1,0,1…

## Test plan
- Single ADD:
  - Stimulus: after reset, req0 a=5, b=7, op=0010.
  - `req0_ready`=1 at T; `rsp0_valid`=1 after T+1 with `rsp0_s`=12, `rsp0_z`=0.
  - `rsp1_valid` stays 0.
- Zero flag and SLT:
  - req1 SUB 3−3 (op=0110) → `rsp1_s`=0, `rsp1_z`=1.
  - Then req1 SLT a=−1, b=1 (op=0111) → `rsp1_s`=1, `rsp1_z`=0.
- Simultaneous requests:
  - Stimulus: after reset, req0 AND 0xF0F0_F0F0&0xFF00_FF00 and req1 OR 0x1|0x2 held valid together, rsp ready tied high.
  - req0 is served first → 0xF000_F000.
  - req1 is accepted 3 cycles later → 3.
  - Next tie goes to req0.
- Backpressure:
  - Stimulus: hold `rsp0_ready`=0 for 4 cycles after `rsp0_valid` rises, with req1 valid throughout.
  - `rsp0_s`/`rsp0_z`/`rsp0_valid` stay stable and `req1_ready` stays 0.
  - req1 is accepted the cycle after `rsp0_ready` pulses.
- Reset mid-operation:
  - Stimulus: assert `reset` in EXEC.
  - No `rsp_valid` appears.
  - All outputs are at reset values next cycle, and the next tie is granted to req0.
- Unsupported opcode / withdrawn request:
  - req0 op=1111 → `rsp0_s`=0, `rsp0_z`=1.
  - req1 valid for one cycle while busy, then dropped → no grant, and `last_grant` is unchanged.
